// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: opcodes, states,
// datapath select codes and the per-state control decode.
package rv_ctrl_pkg;

    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_I      = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] WRF_MEM    = 2'b00;
    localparam logic [1:0] WRF_PC4    = 2'b01;
    localparam logic [1:0] WRF_ALU    = 2'b10;
    localparam logic [1:0] WRF_IMM    = 2'b11;

    localparam logic [1:0] PC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_TARGET  = 2'b01;
    localparam logic [1:0] PC_JALR    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wrf_sel;
        logic       reg_write;
        logic       busy;
    } ctrl_t;

    function automatic logic opc_known(input logic [4:0] opc);
        return (opc == OPC_R)      || (opc == OPC_I)     || (opc == OPC_LOAD) ||
               (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL) ||
               (opc == OPC_JALR)   || (opc == OPC_LUI)   || (opc == OPC_AUIPC);
    endfunction

    // Moore control word for a state; the handshake-dependent strobes are added by the top.
    function automatic ctrl_t ctrl_decode(input state_t st, input logic [4:0] opc);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.busy      = 1'b1;
                c.mem_req   = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_PLUS4;
            end
            ST_DECODE: begin
                c.busy      = 1'b1;
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_EXEC: begin
                c.busy = 1'b1;
                case (opc)
                    OPC_R, OPC_I: begin
                        c.alu_src_a = SRCA_RS1;
                        c.alu_src_b = (opc == OPC_R) ? SRCB_RS2 : SRCB_IMM;
                        c.alu_op    = ALU_FUNCT;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        c.alu_src_a = SRCA_RS1;
                        c.alu_src_b = SRCB_IMM;
                        c.alu_op    = ALU_ADD;
                    end
                    OPC_BRANCH: begin
                        c.alu_src_a     = SRCA_RS1;
                        c.alu_src_b     = SRCB_RS2;
                        c.alu_op        = ALU_BRANCH;
                        c.pc_write_cond = 1'b1;
                        c.pc_src        = PC_TARGET;
                    end
                    OPC_JAL: begin
                        c.pc_write  = 1'b1;
                        c.pc_src    = PC_TARGET;
                        c.reg_write = 1'b1;
                        c.wrf_sel   = WRF_PC4;
                    end
                    OPC_JALR: begin
                        c.alu_src_a = SRCA_RS1;
                        c.alu_src_b = SRCB_IMM;
                        c.pc_write  = 1'b1;
                        c.pc_src    = PC_JALR;
                        c.reg_write = 1'b1;
                        c.wrf_sel   = WRF_PC4;
                    end
                    OPC_LUI, OPC_AUIPC: begin
                        c.reg_write = 1'b1;
                        c.wrf_sel   = WRF_IMM;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                c.busy    = 1'b1;
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = (opc == OPC_STORE);
            end
            ST_WB: begin
                c.busy      = 1'b1;
                c.reg_write = 1'b1;
                c.wrf_sel   = (opc == OPC_LOAD) ? WRF_MEM : WRF_ALU;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles within one FETCH/MEM visit and flags expiry
// when the count has reached TIMEOUT and memory is still not ready.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count_reg;

    // Saturates at LIMIT so a disabled timeout (TIMEOUT=0) never counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (waiting && (count_reg != LIMIT)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign expired = (TIMEOUT > 0) && waiting && (count_reg == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath controls, handshakes with memory, traps and counts retirements.
module mc_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int OPC_W   = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wrf_sel,
    output logic             reg_write,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [OPC_W-1:0] opc_reg, opc_next;
    ctrl_t            ctrl_reg;
    logic             trap_reg;
    logic [1:0]       trap_cause_reg, cause_next;
    logic [CNT_W-1:0] instret_reg;
    logic             retire;
    logic             timed_out;
    logic             mem_wait;

    assign ir_write = (state_reg == ST_FETCH) && mem_ready;
    assign opc_next = ir_write ? opcode : opc_reg;
    assign mem_wait = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_next != state_reg),
        .waiting (mem_wait),
        .expired (timed_out)
    );

    always_comb begin
        state_next = state_reg;
        cause_next = TRAP_NONE;
        retire     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timed_out) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (opc_known(opc_reg)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (opc_reg)
                    OPC_R, OPC_I:         state_next = ST_WB;
                    OPC_LOAD, OPC_STORE:  state_next = ST_MEM;
                    OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                    default: begin
                        state_next = ST_TRAP;
                        cause_next = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (opc_reg == OPC_STORE) begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (timed_out) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_TIMEOUT;
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control word is registered against the next state, so it is a pure
    // function of the state register as seen from outside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            opc_reg        <= '0;
            ctrl_reg       <= '0;
            trap_reg       <= 1'b0;
            trap_cause_reg <= TRAP_NONE;
            instret_reg    <= '0;
        end else begin
            state_reg <= state_next;
            opc_reg   <= opc_next;
            ctrl_reg  <= ctrl_decode(state_next, opc_next);
            if (retire) instret_reg <= instret_reg + CNT_ONE;
            if ((state_next == ST_TRAP) && (state_reg != ST_TRAP)) begin
                trap_reg       <= 1'b1;
                trap_cause_reg <= cause_next;
            end
        end
    end

    assign mem_req       = ctrl_reg.mem_req;
    assign mem_we        = ctrl_reg.mem_we;
    assign iord          = ctrl_reg.iord;
    assign pc_write      = ctrl_reg.pc_write | ir_write;
    assign pc_write_cond = ctrl_reg.pc_write_cond;
    assign pc_src        = ctrl_reg.pc_src;
    assign alu_src_a     = ctrl_reg.alu_src_a;
    assign alu_src_b     = ctrl_reg.alu_src_b;
    assign alu_op        = ctrl_reg.alu_op;
    assign wrf_sel       = ctrl_reg.wrf_sel;
    assign reg_write     = ctrl_reg.reg_write;
    assign busy          = ctrl_reg.busy;
    assign trap          = trap_reg;
    assign trap_cause    = trap_cause_reg;
    assign instret       = instret_reg;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the RISC-V core; it replaces the single-cycle opcode decoder.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives datapath enables and mux selects per state.
- Runs a valid/ready handshake with a shared instruction/data memory, with a bounded wait.
- Traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- OPC_W, 5, opcode field width (instr[6:2]).
- TIMEOUT, 15, maximum mem_ready wait cycles before trapping; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  leave IDLE and begin fetching.
- opcode  in  OPC_W  instr[6:2] from memory read data; sampled only while ir_write=1.
- mem_ready  in  1  memory accepted or completed the current request.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write.
- iord  out  1  0 selects PC as the memory address, 1 selects the ALU result.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if the ALU zero/branch flag is set.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch/jal target, 10 = jalr ALU result.
- alu_src_a  out  2  ALU A source: 00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  out  2  ALU B source: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- wrf_sel  out  2  register write-back source: 00 = memory, 01 = PC+4, 10 = ALU, 11 = imm/auipc.
- reg_write  out  1  register file write enable.
- busy  out  1  state is not IDLE and not TRAP.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - Latched opcode, wait counter and instret = 0; trap = 0, trap_cause = 00.
  - Every output is 0.
- Latched opcode: opc_q captures opcode on the cycle ir_write=1. Every later state decodes opc_q, never the live port.
- Outputs: Moore, decoded from the state register. Exceptions: ir_write, and the memory-completion transitions, which depend on mem_ready in the same cycle. Any output not listed for a state is 0.
- IDLE:
  - Stay while run=0.
  - When run=1, go to FETCH.
- FETCH:
  - Drive mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00, pc_src=00.
  - When mem_ready=1: also drive ir_write=1 and pc_write=1, then go to DECODE.
- DECODE:
  - Drive alu_src_a=10, alu_src_b=01, alu_op=00 to precompute the target.
  - Known opcodes (01100, 00100, 00000, 01000, 11000, 11011, 11001, 01101, 00101) go to EXEC.
  - Any other opcode goes to TRAP with trap_cause=01.
- EXEC, by opcode:
  - R (01100) and I (00100): alu_src_a=01, alu_src_b = 00 for R / 01 for I, alu_op=10; go to WB.
  - Load (00000) and store (01000): alu_src_a=01, alu_src_b=01, alu_op=00; go to MEM.
  - Branch (11000): alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; retire, go to FETCH.
  - jal (11011): pc_write=1, pc_src=01, reg_write=1, wrf_sel=01; retire, go to FETCH.
  - jalr (11001): alu_src_a=01, alu_src_b=01, pc_write=1, pc_src=10, reg_write=1, wrf_sel=01; retire, go to FETCH.
  - lui (01101) and auipc (00101): reg_write=1, wrf_sel=11; retire, go to FETCH.
- MEM:
  - Drive mem_req=1, iord=1, mem_we = (opc_q is store).
  - When mem_ready=1: a store retires and goes to FETCH; a load goes to WB.
- WB:
  - Drive reg_write=1, wrf_sel = 00 for a load, 10 otherwise.
  - Retire, go to FETCH.
- Memory wait counter:
  - Counts cycles in FETCH or MEM with mem_ready=0, and clears on every state change.
  - With TIMEOUT>0: if the count reaches TIMEOUT while mem_ready=0, go to TRAP with cause 10 on the next edge.
  - A mem_ready=1 arriving in the same cycle as the count reaching TIMEOUT wins: normal completion, no trap.
- TRAP:
  - All control outputs are 0; trap=1 and trap_cause hold.
  - Exit only via reset.
- Retire: instret increments by 1 on each retiring transition. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready held 1), in cycles from entering FETCH:
  - R/I: 4.
  - load: 5.
  - store: 4.
  - branch, jal, jalr, lui, auipc: 3.
- run is ignored outside IDLE. The FSM never returns to IDLE except through reset.
- Reset asserted mid-instruction aborts immediately: mem_req drops asynchronously, and no retire is counted.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - the state enum;
  - alu_op, wrf_sel, pc_src and trap_cause encodings.
- One natural sub-module: mem_wait_timer (the wait counter and timeout compare, parameterised by TIMEOUT).

Test Plan:
- Reset, then run=1 with zero-wait memory, R-type 01100:
  - states IDLE, FETCH, DECODE, EXEC, WB, FETCH;
  - reg_write=1 with wrf_sel=10 in WB only;
  - instret=1 after 4 cycles.
- Load 00000 with mem_ready low for 3 cycles in MEM:
  - mem_req=1, iord=1, mem_we=0 held for 4 cycles;
  - then WB with wrf_sel=00;
  - load total is 8 cycles.
- Store 01000:
  - MEM drives mem_we=1, reg_write is never 1;
  - retires to FETCH; instret increments by 1.
- jal 11011 followed by branch 11000:
  - each takes 3 cycles;
  - jal: pc_write=1, pc_src=01, wrf_sel=01 in EXEC;
  - branch: pc_write_cond=1, alu_op=01.
- Illegal opcode 11111:
  - TRAP after DECODE with trap=1, trap_cause=01;
  - all outputs 0 and instret unchanged over 20 cycles;
  - rst_n low clears the trap.
- TIMEOUT=15 with mem_ready stuck at 0 in FETCH: TRAP with cause 10 exactly 16 cycles after entering FETCH.
- TIMEOUT=15 with mem_ready=1 on the 15th wait cycle: normal DECODE, no trap.
